// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: FSM states, next-PC select codes
// and the instruction size used for sequential PC advance.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HOLD,
    HALTED
  } state_e;

  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_REDIR,
    SEL_TRAP,
    SEL_HOLD
  } pc_sel_e;

  localparam int unsigned INSTR_BYTES = 4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request bus and decode-side valid/ready handshake.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ready, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ready, imem_rdata, instr_ready
  );
endinterface

// File: rtl/next_pc_mux.sv
// Priority select of the next PC (trap > redirect > sequential > hold)
// with detection of misaligned redirect targets.
module next_pc_mux
  import fetch_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap,
  input  logic        advance,
  output logic [31:0] next_pc,
  output logic        misalign_next
);

  pc_sel_e sel;

  always_comb begin
    sel = SEL_HOLD;
    if (trap)                sel = SEL_TRAP;
    else if (redirect_valid) sel = SEL_REDIR;
    else if (advance)        sel = SEL_SEQ;
  end

  // A misaligned redirect is turned into a trap-vector redirect here.
  always_comb begin
    next_pc       = pc;
    misalign_next = 1'b0;
    case (sel)
      SEL_SEQ:   next_pc = pc + 32'(INSTR_BYTES);
      SEL_REDIR: begin
        if (is_misaligned(redirect_target)) begin
          next_pc       = TRAP_VECTOR;
          misalign_next = 1'b1;
        end else begin
          next_pc = redirect_target;
        end
      end
      SEL_TRAP:  next_pc = TRAP_VECTOR;
      default:   next_pc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC register, issues one instruction fetch per cycle and hands
// each fetched word to decode through a valid/ready register stage.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  input  logic               trap,
  input  logic               halt_req,
  fetch_sequencer_if.master  bus,
  output logic               misalign,
  output logic               halted
);

  state_e      state;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        misalign_next;

  logic trap_en;
  logic redir_en;
  logic flush;
  logic can_capture;
  logic fire;

  // Trap is honoured everywhere but BOOT; redirects only while fetching or holding.
  assign trap_en     = trap && (state != BOOT);
  assign redir_en    = redirect_valid && (state == FETCH || state == HOLD);
  assign flush       = trap_en || redir_en;
  assign can_capture = !bus.instr_valid || bus.instr_ready;
  assign fire        = (state == FETCH) && !flush && bus.imem_ready && can_capture;

  assign bus.imem_req  = (state == FETCH);
  assign bus.imem_addr = pc;

  next_pc_mux #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_pc_mux (
    .pc              (pc),
    .redirect_valid  (redir_en),
    .redirect_target (redirect_target),
    .trap            (trap_en),
    .advance         (fire),
    .next_pc         (next_pc),
    .misalign_next   (misalign_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= BOOT;
      pc              <= RESET_VECTOR;
      bus.instr_valid <= 1'b0;
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
      misalign        <= 1'b0;
      halted          <= 1'b0;
    end else begin
      pc       <= next_pc;
      misalign <= misalign_next;
      if (flush) begin
        bus.instr_valid <= 1'b0;
        state           <= FETCH;
        halted          <= 1'b0;
      end else begin
        case (state)
          BOOT: begin
            state  <= FETCH;
            halted <= 1'b0;
          end
          FETCH: begin
            if (fire) begin
              bus.instr       <= bus.imem_rdata;
              bus.instr_pc    <= pc;
              bus.instr_valid <= 1'b1;
            end else if (bus.instr_ready) begin
              bus.instr_valid <= 1'b0;
            end
            // Halt wins over HOLD: the held word drains from HALTED instead.
            if (halt_req) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else if (!fire && bus.instr_valid && !bus.instr_ready) begin
              state <= HOLD;
            end
          end
          HOLD: begin
            if (bus.instr_ready) begin
              bus.instr_valid <= 1'b0;
              state           <= halt_req ? HALTED : FETCH;
              halted          <= halt_req;
            end
          end
          HALTED: begin
            if (bus.instr_ready) bus.instr_valid <= 1'b0;
            if (!halt_req) begin
              state  <= FETCH;
              halted <= 1'b0;
            end
          end
          default: begin
            state  <= BOOT;
            halted <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, backpressure,
// redirect/misalign/trap, halt/resume, reset in HOLD and PC wrap.
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;
  logic        halt_req;
  logic        misalign;
  logic        halted;
  logic        mem_ready;
  logic        dec_ready;
  int          total = 0;
  int          bad   = 0;

  fetch_sequencer_if bus ();

  // Memory returns a word tagged with its own address.
  assign bus.imem_ready  = mem_ready;
  assign bus.imem_rdata  = 32'hC0DE_0000 ^ bus.imem_addr;
  assign bus.instr_ready = dec_ready;

  fetch_sequencer #(
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap            (trap),
    .halt_req        (halt_req),
    .bus             (bus.master),
    .misalign        (misalign),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = '0;
    trap = 1'b0; halt_req = 1'b0; mem_ready = 1'b0; dec_ready = 1'b0;
    tick();
    chk("rst_req",      {31'd0, bus.imem_req},    32'd0);
    chk("rst_valid",    {31'd0, bus.instr_valid}, 32'd0);
    chk("rst_halted",   {31'd0, halted},          32'd0);
    chk("rst_misalign", {31'd0, misalign},        32'd0);
    chk("rst_addr",     bus.imem_addr,            32'h0);
    chk("rst_instr",    bus.instr,                32'h0);
    chk("rst_ipc",      bus.instr_pc,             32'h0);

    reset = 1'b0; mem_ready = 1'b1; dec_ready = 1'b1;
    tick();  // BOOT -> FETCH
    chk("boot_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("boot_addr", bus.imem_addr,         32'h0);
    chk("boot_vld",  {31'd0, bus.instr_valid}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("seq_addr",  bus.imem_addr, 32'(i * 4));
      chk("seq_ipc",   bus.instr_pc,  32'((i - 1) * 4));
      chk("seq_instr", bus.instr,     32'hC0DE_0000 ^ 32'((i - 1) * 4));
      chk("seq_vld",   {31'd0, bus.instr_valid}, 32'd1);
    end

    // Backpressure while instr_pc=8
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_req",  {31'd0, bus.imem_req},    32'd0);
      chk("hold_ipc",  bus.instr_pc,             32'h8);
      chk("hold_inst", bus.instr,                32'hC0DE_0008);
      chk("hold_vld",  {31'd0, bus.instr_valid}, 32'd1);
      chk("hold_addr", bus.imem_addr,            32'hC);
    end
    dec_ready = 1'b1;
    tick();
    chk("rel_vld",  {31'd0, bus.instr_valid}, 32'd0);
    chk("rel_req",  {31'd0, bus.imem_req},    32'd1);
    chk("rel_addr", bus.imem_addr,            32'hC);
    tick();
    chk("rel_ipc",  bus.instr_pc,  32'hC);
    chk("rel_next", bus.imem_addr, 32'h10);

    // Aligned redirect drops the word fetched at 0x10
    redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    chk("redir_addr", bus.imem_addr,            32'h40);
    chk("redir_vld",  {31'd0, bus.instr_valid}, 32'd0);
    chk("redir_mis",  {31'd0, misalign},        32'd0);
    tick();
    chk("redir_ipc", bus.instr_pc,             32'h40);
    chk("redir_v2",  {31'd0, bus.instr_valid}, 32'd1);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_target = 32'h42;
    tick();
    redirect_valid = 1'b0;
    chk("mis_pulse", {31'd0, misalign}, 32'd1);
    chk("mis_addr",  bus.imem_addr,     32'h100);
    tick();
    chk("mis_clear", {31'd0, misalign}, 32'd0);
    chk("mis_ipc",   bus.instr_pc,      32'h100);
    chk("mis_inst",  bus.instr,         32'hC0DE_0100);

    // Trap and misaligned redirect together: trap wins, no misalign
    trap = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h83;
    tick();
    trap = 1'b0; redirect_valid = 1'b0;
    chk("trap_addr", bus.imem_addr,            32'h100);
    chk("trap_mis",  {31'd0, misalign},        32'd0);
    chk("trap_vld",  {31'd0, bus.instr_valid}, 32'd0);
    tick();
    chk("trap_ipc", bus.instr_pc, 32'h100);

    // Halt with a completing fetch at 0x104
    halt_req = 1'b1;
    tick();
    chk("halt_ipc", bus.instr_pc,             32'h104);
    chk("halt_vld", {31'd0, bus.instr_valid}, 32'd1);
    chk("halt_hl",  {31'd0, halted},          32'd1);
    chk("halt_req", {31'd0, bus.imem_req},    32'd0);
    tick();
    chk("halt_drain", {31'd0, bus.instr_valid}, 32'd0);
    chk("halt_hl2",   {31'd0, halted},          32'd1);
    chk("halt_pc",    bus.imem_addr,            32'h108);
    halt_req = 1'b0;
    tick();
    chk("resume_hl",   {31'd0, halted},       32'd0);
    chk("resume_req",  {31'd0, bus.imem_req}, 32'd1);
    chk("resume_addr", bus.imem_addr,         32'h108);
    tick();
    chk("resume_ipc", bus.instr_pc, 32'h108);

    // Reach HOLD with pc=0x200, then reset
    redirect_valid = 1'b1; redirect_target = 32'h1FC;
    tick();
    redirect_valid = 1'b0;
    tick();
    dec_ready = 1'b0;
    tick();
    chk("pre_rst_req",  {31'd0, bus.imem_req}, 32'd0);
    chk("pre_rst_addr", bus.imem_addr,         32'h200);
    chk("pre_rst_ipc",  bus.instr_pc,          32'h1FC);
    reset = 1'b1;
    tick();
    reset = 1'b0; dec_ready = 1'b1;
    chk("hrst_addr", bus.imem_addr,            32'h0);
    chk("hrst_vld",  {31'd0, bus.instr_valid}, 32'd0);
    chk("hrst_hl",   {31'd0, halted},          32'd0);
    chk("hrst_req",  {31'd0, bus.imem_req},    32'd0);
    chk("hrst_ipc",  bus.instr_pc,             32'h0);

    // PC wrap; redirect held through BOOT is ignored there
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_boot", bus.imem_addr, 32'h0);
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_ipc", bus.instr_pc,  32'hFFFF_FFFC);
    chk("wrap_pc",  bus.imem_addr, 32'h0);

    // Memory stall keeps the request up at the same address
    mem_ready = 1'b0;
    tick();
    chk("stall_req",  {31'd0, bus.imem_req},    32'd1);
    chk("stall_addr", bus.imem_addr,            32'h0);
    chk("stall_vld",  {31'd0, bus.instr_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls the core's program counter register and the instruction-memory request. It holds the PC, issues one fetch per cycle, and delivers each instruction to decode through a valid/ready handshake. It selects the next PC among sequential, branch/jump redirect and trap vector, and supports halt/resume.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned redirect; bits[1:0] must be 0

Ports:
clk  input  1  core clock; all state updates on posedge
reset  input  1  synchronous, active-high; sampled on posedge clk
redirect_valid  input  1  branch/jump taken this cycle
redirect_target  input  32  redirect destination PC
trap  input  1  exception/interrupt; redirect to TRAP_VECTOR
halt_req  input  1  level; stop fetching
imem_req  output  1  instruction fetch request
imem_addr  output  32  fetch address; always equals the PC register
imem_ready  input  1  memory accepts the request and returns imem_rdata in the same cycle
imem_rdata  input  32  fetched instruction word
instr_valid  output  1  instr/instr_pc hold a live instruction
instr_ready  input  1  decode accepts the instruction
instr  output  32  registered instruction word
instr_pc  output  32  address of instr
misalign  output  1  one-cycle pulse: redirect target with bits[1:0] != 0
halted  output  1  high while in HALTED

Behaviour:
- Reset: synchronous and active-high, highest priority. On a reset edge: pc=RESET_VECTOR, state=BOOT, instr_valid=0, instr=0, instr_pc=0, misalign=0, halted=0. imem_req=0 while in BOOT. Reset mid-fetch discards any outstanding data.
- States: BOOT, FETCH, HOLD, HALTED.
- BOOT: go to FETCH on the next edge. No request is issued in BOOT.
- FETCH: imem_req=1, imem_addr=pc.
  - If imem_ready=1: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - If imem_ready=0: stay in FETCH and keep the request asserted.
- Backpressure:
  - In FETCH, a new capture is allowed only if instr_valid=0, or instr_valid=1 with instr_ready=1 in the same cycle. This gives 1 instruction/cycle throughput.
  - If instr_valid=1 and instr_ready=0: go to HOLD. In HOLD, imem_req=0 and instr, instr_pc, instr_valid and pc are all frozen.
  - HOLD returns to FETCH on the edge where instr_ready=1. instr_valid clears on that edge unless a new capture occurs.
- Next-PC priority, evaluated every cycle outside BOOT: reset > trap > redirect_valid > halt_req > sequential.
  - trap: pc<=TRAP_VECTOR, instr_valid<=0 (flush), any imem_rdata this cycle is discarded, state=FETCH. trap is honoured from any state, including HOLD and HALTED.
  - redirect_valid with target[1:0]==0: pc<=redirect_target, instr_valid<=0, imem_rdata this cycle is discarded, state=FETCH. This also applies from HOLD. redirect_valid is ignored in HALTED.
  - redirect_valid with target[1:0]!=0: pc<=TRAP_VECTOR, misalign=1 for exactly one cycle, flush as above.
  - Simultaneous trap and redirect: trap wins and misalign stays 0.
- imem_addr is not required to stay stable while imem_ready=0 if a flush changes pc. The memory must tolerate an abandoned request.
- halt_req:
  - Sampled in FETCH or HOLD.
  - In FETCH: the fetch in progress completes (if imem_ready=1 that cycle), then the block enters HALTED. A fetch that has not completed is abandoned.
  - In HOLD: the block waits for the held instruction to be accepted, then enters HALTED.
  - In HALTED: imem_req=0, halted=1, pc frozen, and instr_valid drains normally through the handshake.
  - HALTED returns to FETCH on the cycle after halt_req deasserts.
- Outputs instr, instr_pc, instr_valid, misalign and halted are registered. imem_req and imem_addr are decoded from state and the pc register.

Decomposition:
- Package fetch_pkg: state enum {BOOT, FETCH, HOLD, HALTED}; INSTR_BYTES=4; next-PC select enum {SEL_SEQ, SEL_REDIR, SEL_TRAP, SEL_HOLD}.
- One sub-module, next_pc_mux: combinational priority select plus misalign detect. Inputs are pc, redirect_valid, redirect_target, trap, advance. Outputs are next_pc and misalign_next.
- The FSM and output registers stay in fetch_sequencer. The existing PC register is absorbed into this block.

Test Plan:
- Reset, then imem_ready=1 and instr_ready=1 for 4 cycles -> BOOT for 1 cycle; imem_addr 0,4,8,C on consecutive cycles; instr_pc follows one cycle later; instr_valid=1 continuously.
- instr_ready=0 for 3 cycles while instr_pc=8 -> HOLD; imem_req=0; instr/instr_pc frozen. Release instr_ready -> next fetch at addr C with no duplicate and no skipped instruction.
- redirect_valid=1, target=32'h40, in the same cycle imem_ready=1 at addr 10 -> addr-10 data dropped; next imem_addr=40; instr_valid=0 for one cycle.
- redirect target=32'h42 -> misalign pulse of 1 cycle; next imem_addr=TRAP_VECTOR (0x100). trap and redirect together -> 0x100 with misalign=0.
- halt_req during FETCH with imem_ready=1 -> that instruction delivered, then halted=1 and imem_req=0. Deassert halt_req -> fetch resumes at the saved pc.
- reset asserted mid-HOLD with pc=0x200 -> next cycle pc=RESET_VECTOR, instr_valid=0, halted=0, state BOOT. pc=FFFF_FFFC with sequential fetch -> next pc=0.
